interrupt_sequencer: RTL and testbench

Priority resolver and INTA sequencer for the 8-level programmable interrupt controller.
- Arbitrates the unmasked requests in IRR, raises INT and tracks the two-pulse INTA handshake.
- Owns the in-service register (ISR) and the rotating priority pointer.
- Supplies isr_highest_bit, number_of_ack and send_vector_address to the control logic, which builds the vector and drives the data bus.

---
 rtl/interrupt_sequencer.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer
// Priority resolver and INTA sequencer for the 8-level programmable
// interrupt controller. Arbitrates unmasked requests, raises int_out,
// follows the two-pulse INTA handshake, owns the in-service register
// and the rotating priority pointer.
//
// Optional feature macro: ROTATE_AEOI_EN
//   defined   -> OCW2 100/000 set/clear a rotate-in-AEOI flag; with
//                auto_eoi set, the end of an acknowledge also rotates
//                the priority so the serviced level becomes lowest.
//   undefined -> OCW2 100/000 are no-ops and AEOI never rotates.
//
// Ports:
//   clk                 system clock
//   rst_n               asynchronous active-low reset
//   irr                 interrupt request register
//   imr                 interrupt mask, 1 = masked
//   ocw2                OCW2 command byte
//   ocw2_wr             one-clock strobe qualifying ocw2
//   auto_eoi            AEOI mode from ICW4
//   inta_n              interrupt acknowledge, active low, clk-synchronous
//   int_out             interrupt request to the CPU
//   isr                 in-service register
//   isr_highest_bit     one-hot level being acknowledged
//   number_of_ack       INTA pulses seen in the current sequence
//   send_vector_address control logic drives the vector onto the bus
//   irr_clear           one-clock one-hot pulse telling IRR to clear a bit

module interrupt_sequencer #(
   parameter int         NUM_IRQ        = 8,
   parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irr,
   input  logic [NUM_IRQ-1:0] imr,
   input  logic [7:0]         ocw2,
   input  logic               ocw2_wr,
   input  logic               auto_eoi,
   input  logic               inta_n,
   output logic               int_out,
   output logic [NUM_IRQ-1:0] isr,
   output logic [NUM_IRQ-1:0] isr_highest_bit,
   output logic [1:0]         number_of_ack,
   output logic               send_vector_address,
   output logic [NUM_IRQ-1:0] irr_clear
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK1 = 2'd1,
      ACK2 = 2'd2
   } state_t;

   localparam logic [NUM_IRQ-1:0] ONE_HOT_BASE = NUM_IRQ'(1);

   state_t             state_q;
   logic               inta_q;
   logic               int_out_q;
   logic [NUM_IRQ-1:0] isr_q;
   logic [NUM_IRQ-1:0] isr_d;
   logic [NUM_IRQ-1:0] isr_highest_bit_q;
   logic [1:0]         number_of_ack_q;
   logic               send_vector_address_q;
   logic [NUM_IRQ-1:0] irr_clear_q;
   logic [2:0]         lowest_priority_q;
   logic [2:0]         lowest_priority_d;
   logic [2:0]         lvl_q;
   logic               spurious_q;
   logic               rotate_aeoi;
`ifdef ROTATE_AEOI_EN
   logic               rotate_aeoi_q;
`endif

   logic [NUM_IRQ-1:0] cand;
   logic [2:0]         startLevel;
   logic [2:0]         scanLevel;
   logic               selValid;
   logic [2:0]         selLevel;
   logic [2:0]         selRank;
   logic               topValid;
   logic [2:0]         topLevel;
   logic [2:0]         topRank;
   logic               pending;

   logic               fallEdge;
   logic               riseEdge;

   logic [NUM_IRQ-1:0] ocwClrMask;
   logic               ocwRotate;
   logic [2:0]         ocwRotLevel;
   logic               ocwAeoiSet;
   logic               ocwAeoiClr;
   logic [1:0]         ocwFieldUnused;

   logic [2:0]         ackLevel;
   logic [NUM_IRQ-1:0] isrSetMask;
   logic               aeoiClear;
   logic [NUM_IRQ-1:0] aeoiClrMask;
   logic               aeoiRotate;

   assign cand       = irr & ~imr;
   assign startLevel = lowest_priority_q + 3'd1;
   assign fallEdge   = inta_q & ~inta_n;
   assign riseEdge   = ~inta_q & inta_n;

   // bits [4:3] only identify the word as an OCW2 and carry no command
   assign ocwFieldUnused = ocw2[4:3];

   // Walk the levels from the highest-priority position down to the
   // lowest. Scanning the ranks in reverse lets the highest-priority hit
   // be the last assignment, giving both the winning level and its rank.
   always_comb begin
      scanLevel = 3'd0;
      selValid  = 1'b0;
      selLevel  = 3'd0;
      selRank   = 3'd0;
      topValid  = 1'b0;
      topLevel  = 3'd0;
      topRank   = 3'd0;
      for (int k = NUM_IRQ - 1; k >= 0; k--) begin
         scanLevel = startLevel + 3'(k);
         if (cand[scanLevel]) begin
            selValid = 1'b1;
            selLevel = scanLevel;
            selRank  = 3'(k);
         end
         if (isr_q[scanLevel]) begin
            topValid = 1'b1;
            topLevel = scanLevel;
            topRank  = 3'(k);
         end
      end
   end

   // Fully nested mode: a request only interrupts when nothing is in
   // service or it outranks the highest level already in service.
   assign pending = selValid && (!topValid || (selRank < topRank));

   // OCW2 command decode. Non-specific forms act on the highest level in
   // service and do nothing at all when the ISR is empty.
   always_comb begin
      ocwClrMask  = '0;
      ocwRotate   = 1'b0;
      ocwRotLevel = lowest_priority_q;
      ocwAeoiSet  = 1'b0;
      ocwAeoiClr  = 1'b0;
      if (ocw2_wr) begin
         case (ocw2[7:5])
            3'b001: begin
               if (topValid) begin
                  ocwClrMask = ONE_HOT_BASE << topLevel;
               end
            end
            3'b011: begin
               ocwClrMask = ONE_HOT_BASE << ocw2[2:0];
            end
            3'b101: begin
               if (topValid) begin
                  ocwClrMask  = ONE_HOT_BASE << topLevel;
                  ocwRotate   = 1'b1;
                  ocwRotLevel = topLevel;
               end
            end
            3'b111: begin
               ocwClrMask  = ONE_HOT_BASE << ocw2[2:0];
               ocwRotate   = 1'b1;
               ocwRotLevel = ocw2[2:0];
            end
            3'b110: begin
               ocwRotate   = 1'b1;
               ocwRotLevel = ocw2[2:0];
            end
            3'b100: begin
               ocwAeoiSet = 1'b1;
            end
            3'b000: begin
               ocwAeoiClr = 1'b1;
            end
            default: begin
               ocwRotate = 1'b0;
            end
         endcase
      end
   end

`ifdef ROTATE_AEOI_EN
   assign rotate_aeoi = rotate_aeoi_q;
`else
   assign rotate_aeoi = 1'b0;
`endif

   // Handshake side effects on the ISR and priority pointer. The EOI
   // clear is applied first so an acknowledge set of the same bit wins.
   always_comb begin
      ackLevel    = pending ? selLevel : SPURIOUS_LEVEL;
      isrSetMask  = '0;
      if ((state_q == IDLE) && fallEdge && pending) begin
         isrSetMask = ONE_HOT_BASE << selLevel;
      end
      aeoiClear   = (state_q == ACK2) && riseEdge && auto_eoi && !spurious_q;
      aeoiClrMask = aeoiClear ? (ONE_HOT_BASE << lvl_q) : '0;
      aeoiRotate  = aeoiClear && rotate_aeoi;
      isr_d       = (isr_q & ~ocwClrMask & ~aeoiClrMask) | isrSetMask;
      if (aeoiRotate) begin
         lowest_priority_d = lvl_q;
      end else if (ocwRotate) begin
         lowest_priority_d = ocwRotLevel;
      end else begin
         lowest_priority_d = lowest_priority_q;
      end
   end

`ifdef ROTATE_AEOI_EN
   // Rotate-in-AEOI flag, set and cleared by OCW2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rotate_aeoi_q <= 1'b0;
      end else if (ocwAeoiSet) begin
         rotate_aeoi_q <= 1'b1;
      end else if (ocwAeoiClr) begin
         rotate_aeoi_q <= 1'b0;
      end
   end
`endif

   // INTA sequencer: IDLE waits for the first INTA falling edge and
   // latches the level, ACK1 waits for the second falling edge, ACK2
   // holds the vector on the bus until INTA rises again.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q               <= IDLE;
         inta_q                <= 1'b1;
         int_out_q             <= 1'b0;
         isr_q                 <= '0;
         isr_highest_bit_q     <= '0;
         number_of_ack_q       <= 2'd0;
         send_vector_address_q <= 1'b0;
         irr_clear_q           <= '0;
         lowest_priority_q     <= 3'd7;
         lvl_q                 <= 3'd0;
         spurious_q            <= 1'b0;
      end else begin
         inta_q            <= inta_n;
         irr_clear_q       <= '0;
         isr_q             <= isr_d;
         lowest_priority_q <= lowest_priority_d;
         case (state_q)
            IDLE: begin
               int_out_q <= pending;
               if (fallEdge) begin
                  lvl_q             <= ackLevel;
                  spurious_q        <= !pending;
                  irr_clear_q       <= isrSetMask;
                  isr_highest_bit_q <= ONE_HOT_BASE << ackLevel;
                  number_of_ack_q   <= 2'd1;
                  int_out_q         <= 1'b0;
                  state_q           <= ACK1;
               end
            end
            ACK1: begin
               int_out_q <= 1'b0;
               if (fallEdge) begin
                  number_of_ack_q       <= 2'd2;
                  send_vector_address_q <= 1'b1;
                  state_q               <= ACK2;
               end
            end
            ACK2: begin
               int_out_q <= 1'b0;
               if (riseEdge) begin
                  number_of_ack_q       <= 2'd0;
                  send_vector_address_q <= 1'b0;
                  state_q               <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign int_out             = int_out_q;
   assign isr                 = isr_q;
   assign isr_highest_bit     = isr_highest_bit_q;
   assign number_of_ack       = number_of_ack_q;
   assign send_vector_address = send_vector_address_q;
   assign irr_clear           = irr_clear_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer
// Drives interrupt_sequencer with a directed walk through the main
// handshake cases followed by randomized requests, masks, OCW2 commands
// and INTA waveforms. A behavioural model of the controller predicts
// every output after each clock.

module tb_interrupt_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] irr = 8'h00;
   logic [7:0] imr = 8'h00;
   logic [7:0] ocw2 = 8'h00;
   logic       ocw2_wr = 1'b0;
   logic       auto_eoi = 1'b0;
   logic       inta_n = 1'b1;
   logic       int_out;
   logic [7:0] isr;
   logic [7:0] isr_highest_bit;
   logic [1:0] number_of_ack;
   logic       send_vector_address;
   logic [7:0] irr_clear;

   int total = 0;
   int bad = 0;

   // Model state: phase counts INTA pulses accepted in the sequence.
   logic [7:0] mIsr;
   int         mLowest;
   int         mPhase;
   bit         mPrevInta;
   int         mLvl;
   bit         mSpur;
   bit         mRotAeoi;
   bit         mInt;
   logic [7:0] mIrrClr;
   logic [7:0] mHigh;
   int         mNum;
   bit         mSend;

   int         intaQ[$];

   interrupt_sequencer dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .irr                 (irr),
      .imr                 (imr),
      .ocw2                (ocw2),
      .ocw2_wr             (ocw2_wr),
      .auto_eoi            (auto_eoi),
      .inta_n              (inta_n),
      .int_out             (int_out),
      .isr                 (isr),
      .isr_highest_bit     (isr_highest_bit),
      .number_of_ack       (number_of_ack),
      .send_vector_address (send_vector_address),
      .irr_clear           (irr_clear)
   );

   // free-running clock
   always #5 clk = ~clk;

   // count one comparison and report it when it disagrees
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // distance from the top of the priority order; 0 is served first
   function automatic int rankOf(input int level);
      return (level - mLowest + 7) % 8;
   endfunction

   function automatic int bestLevel(input logic [7:0] v);
      int best;
      best = -1;
      for (int l = 0; l < 8; l++) begin
         if (v[l] && (best < 0 || rankOf(l) < rankOf(best))) best = l;
      end
      return best;
   endfunction

   task automatic modelReset();
      mIsr = 8'h00; mLowest = 7; mPhase = 0; mPrevInta = 1'b1;
      mLvl = 0; mSpur = 1'b0; mRotAeoi = 1'b0; mInt = 1'b0;
      mIrrClr = 8'h00; mHigh = 8'h00; mNum = 0; mSend = 1'b0;
   endtask

   // advance the model by one clock using the inputs now applied
   task automatic modelStep();
      logic [7:0] cand;
      logic [7:0] nIsr;
      int sel, top, nLowest, lv;
      bit pend, fall, rise, nRot;
      cand = irr & ~imr;
      sel = bestLevel(cand);
      top = bestLevel(mIsr);
      pend = (sel >= 0) && (top < 0 || rankOf(sel) < rankOf(top));
      fall = mPrevInta && !inta_n;
      rise = !mPrevInta && inta_n;
      nIsr = mIsr;
      nLowest = mLowest;
      nRot = mRotAeoi;
      lv = int'(ocw2[2:0]);
      mIrrClr = 8'h00;
      if (ocw2_wr) begin
         case (ocw2[7:5])
            3'b001: if (top >= 0) nIsr[top] = 1'b0;
            3'b011: nIsr[lv] = 1'b0;
            3'b101: if (top >= 0) begin nIsr[top] = 1'b0; nLowest = top; end
            3'b111: begin nIsr[lv] = 1'b0; nLowest = lv; end
            3'b110: nLowest = lv;
`ifdef ROTATE_AEOI_EN
            3'b100: nRot = 1'b1;
            3'b000: nRot = 1'b0;
`endif
            default: ;
         endcase
      end
      if (mPhase == 0) begin
         mInt = pend;
         if (fall) begin
            mSpur = !pend;
            mLvl = pend ? sel : 7;
            if (pend) begin
               nIsr[sel] = 1'b1;
               mIrrClr = 8'h01 << sel;
            end
            mHigh = 8'h01 << mLvl;
            mNum = 1;
            mInt = 1'b0;
            mPhase = 1;
         end
      end else if (mPhase == 1) begin
         mInt = 1'b0;
         if (fall) begin
            mNum = 2; mSend = 1'b1; mPhase = 2;
         end
      end else begin
         mInt = 1'b0;
         if (rise) begin
            mNum = 0; mSend = 1'b0; mPhase = 0;
            if (auto_eoi && !mSpur) begin
               nIsr[mLvl] = 1'b0;
`ifdef ROTATE_AEOI_EN
               if (mRotAeoi) nLowest = mLvl;
`endif
            end
         end
      end
      mIsr = nIsr;
      mLowest = nLowest;
      mRotAeoi = nRot;
      mPrevInta = inta_n;
   endtask

   // one clock: predict, let the edge pass, then compare every output
   task automatic stepCycle();
      modelStep();
      @(posedge clk);
      #1;
      checkOutput("int_out", {31'd0, int_out}, {31'd0, mInt});
      checkOutput("isr", {24'd0, isr}, {24'd0, mIsr});
      checkOutput("irr_clear", {24'd0, irr_clear}, {24'd0, mIrrClr});
      checkOutput("isr_highest_bit", {24'd0, isr_highest_bit}, {24'd0, mHigh});
      checkOutput("number_of_ack", {30'd0, number_of_ack}, 32'(mNum));
      checkOutput("send_vector_address", {31'd0, send_vector_address}, {31'd0, mSend});
   endtask

   task automatic applyStimulus();
      int a, b, c;
      if (mIrrClr != 8'h00) irr = irr & ~mIrrClr;
      if ($urandom_range(0, 3) == 0) irr = irr | 8'($urandom);
      if ($urandom_range(0, 7) == 0) irr = 8'($urandom);
      if ($urandom_range(0, 15) == 0) imr = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 59) == 0) auto_eoi = ~auto_eoi;
      ocw2_wr = ($urandom_range(0, 9) == 0);
      ocw2 = {3'($urandom), 2'b00, 3'($urandom)};
      if (intaQ.size() == 0 && $urandom_range(0, 9) == 0) begin
         a = $urandom_range(1, 2); b = $urandom_range(1, 2); c = $urandom_range(1, 3);
         for (int i = 0; i < a; i++) intaQ.push_back(0);
         for (int i = 0; i < b; i++) intaQ.push_back(1);
         if ($urandom_range(0, 7) != 0) begin
            for (int i = 0; i < c; i++) intaQ.push_back(0);
         end
         intaQ.push_back(1);
      end
      inta_n = (intaQ.size() != 0) ? intaQ.pop_front() != 0 : 1'b1;
   endtask

   initial begin
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_int_out", {31'd0, int_out}, 32'd0);
      checkOutput("reset_isr", {24'd0, isr}, 32'd0);
      checkOutput("reset_number_of_ack", {30'd0, number_of_ack}, 32'd0);
      checkOutput("reset_highest", {24'd0, isr_highest_bit}, 32'd0);
      rst_n = 1'b1;

      // basic request and full handshake
      irr = 8'h24;
      stepCycle();
      checkOutput("plan_int_rise", {31'd0, int_out}, 32'd1);
      inta_n = 1'b0; stepCycle();
      checkOutput("plan_irr_clear", {24'd0, irr_clear}, 32'h04);
      checkOutput("plan_isr", {24'd0, isr}, 32'h04);
      checkOutput("plan_ack1", {30'd0, number_of_ack}, 32'd1);
      irr = 8'h20; stepCycle();
      checkOutput("plan_irr_clear_pulse", {24'd0, irr_clear}, 32'h00);
      inta_n = 1'b1; stepCycle();
      inta_n = 1'b0; stepCycle();
      checkOutput("plan_ack2", {30'd0, number_of_ack}, 32'd2);
      checkOutput("plan_send", {31'd0, send_vector_address}, 32'd1);
      inta_n = 1'b1; stepCycle();
      checkOutput("plan_send_end", {31'd0, send_vector_address}, 32'd0);

      // nesting: higher level interrupts, lower level waits for EOI
      stepCycle();
      checkOutput("plan_blocked_low", {31'd0, int_out}, 32'd0);
      irr = 8'h01; stepCycle();
      checkOutput("plan_nest_high", {31'd0, int_out}, 32'd1);
      irr = 8'h08; stepCycle(); stepCycle();
      checkOutput("plan_blocked_08", {31'd0, int_out}, 32'd0);
      ocw2 = 8'h20; ocw2_wr = 1'b1; stepCycle();
      ocw2_wr = 1'b0;
      checkOutput("plan_eoi_isr", {24'd0, isr}, 32'h00);
      stepCycle();
      checkOutput("plan_after_eoi", {31'd0, int_out}, 32'd1);

      // set priority so level 3 is highest; level 0 beats level 2
      ocw2 = 8'hC2; ocw2_wr = 1'b1; irr = 8'h05; stepCycle();
      ocw2_wr = 1'b0;
      inta_n = 1'b0; stepCycle();
      checkOutput("plan_rotated_sel", {24'd0, isr_highest_bit}, 32'h01);
      irr = 8'h04;
      inta_n = 1'b1; stepCycle();
      inta_n = 1'b0; stepCycle();
      inta_n = 1'b1; stepCycle();
      irr = 8'h00;
      ocw2 = 8'h20; ocw2_wr = 1'b1; stepCycle();
      ocw2_wr = 1'b0;

      // spurious acknowledge with nothing pending
      inta_n = 1'b0; stepCycle();
      checkOutput("plan_spurious_high", {24'd0, isr_highest_bit}, 32'h80);
      checkOutput("plan_spurious_clr", {24'd0, irr_clear}, 32'h00);
      inta_n = 1'b1; stepCycle();
      inta_n = 1'b0; stepCycle();
      inta_n = 1'b1; stepCycle();

      // automatic EOI clears the in-service bit at the final rising edge
      auto_eoi = 1'b1; irr = 8'h10; stepCycle();
      inta_n = 1'b0; stepCycle();
      irr = 8'h00;
      inta_n = 1'b1; stepCycle();
      inta_n = 1'b0; stepCycle();
      checkOutput("plan_aeoi_held", {24'd0, isr}, 32'h10);
      inta_n = 1'b1; stepCycle();
      checkOutput("plan_aeoi_clear", {24'd0, isr}, 32'h00);

      // asynchronous reset in the middle of ACK2
      auto_eoi = 1'b0; irr = 8'h02; stepCycle();
      inta_n = 1'b0; stepCycle();
      inta_n = 1'b1; stepCycle();
      inta_n = 1'b0; stepCycle();
      #2 rst_n = 1'b0;
      #1;
      checkOutput("areset_isr", {24'd0, isr}, 32'd0);
      checkOutput("areset_send", {31'd0, send_vector_address}, 32'd0);
      checkOutput("areset_num", {30'd0, number_of_ack}, 32'd0);
      checkOutput("areset_high", {24'd0, isr_highest_bit}, 32'd0);
      modelReset();
      inta_n = 1'b1; irr = 8'h00;
      #2 rst_n = 1'b1;
      stepCycle();

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         applyStimulus();
         stepCycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
